// File: rtl/decode_stage.sv
// decode_stage: registered RV32 + RVV OP-V instruction decoder sitting between
// fetch and the instruction buffer. Decode is combinational on in_inst and is
// captured into a main output register (M). A one-entry skid register (S)
// absorbs the single instruction that can arrive after out_ready drops, so
// in_ready is a pure function of registered state (plus rst) and never of
// out_ready.
//
// Handshake: a beat moves on a port exactly when valid && ready are both high
// at the rising edge; the producer holds its payload stable until that edge,
// and valid is never withdrawn by this stage while out_ready is low.
module decode_stage #(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_opt,
  output logic [2:0]            out_funct3,
  output logic [5:0]            out_funct6,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_vm,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  out_illegal
);

  // Major opcodes handled by this stage.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_V   = 7'b1010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // OP-V arithmetic sub-formats supported.
  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPIVX = 3'b100;

  // One decoded instruction, as held in M and S.
  typedef struct packed {
    logic [6:0]            opt;
    logic [2:0]            funct3;
    logic [5:0]            funct6;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm;
    logic                  vm;
    logic [PC_WIDTH-1:0]   pc;
    logic                  illegal;
  } dec_t;

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
    return DATA_WIDTH'($signed(v));
  endfunction

  logic [31:0] inst;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_v;
  dec_t        dec;

  dec_t m_data;
  dec_t s_data;
  logic m_valid;
  logic s_valid;
  logic accept;
  logic transfer;

  assign inst = in_inst[31:0];

  // Raw immediate layouts for every format; all sign from inst[31] except the
  // OPIVI simm5, which carries its own sign bit in inst[19].
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_v = {{27{inst[19]}}, inst[19:15]};

  // Combinational decode of the fetch payload; fields a format lacks stay 0.
  always_comb begin
    dec         = '0;
    dec.opt     = inst[6:0];
    dec.funct3  = inst[14:12];
    dec.pc      = in_pc;
    dec.illegal = (inst[1:0] != 2'b11);
    unique case (inst[6:0])
      OPC_LOAD: begin
        dec.rs1 = inst[19:15];
        dec.rd  = inst[11:7];
        dec.imm = sext32(imm_i);
      end
      OPC_OP_IMM: begin
        dec.rs1 = inst[19:15];
        dec.rd  = inst[11:7];
        dec.imm = sext32(imm_i);
        // SRLI/SRAI are distinguished by inst[30].
        if (inst[14:12] == 3'b101) dec.funct6 = {1'b0, inst[30], 4'b0};
      end
      OPC_JALR: begin
        dec.rs1 = inst[19:15];
        dec.rd  = inst[11:7];
        dec.imm = sext32(imm_i);
        if (inst[14:12] != 3'b000) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.imm = sext32(imm_s);
      end
      OPC_BRANCH: begin
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.imm = sext32(imm_b);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.rd  = inst[11:7];
        dec.imm = sext32(imm_u);
      end
      OPC_JAL: begin
        dec.rd  = inst[11:7];
        dec.imm = sext32(imm_j);
      end
      OPC_OP: begin
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        dec.funct6 = {1'b0, inst[30], 4'b0};
      end
      OPC_OP_V: begin
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        dec.funct6 = inst[31:26];
        dec.vm     = inst[25];
        if (inst[14:12] == F3_OPIVI) dec.imm = sext32(imm_v);
        else if (inst[14:12] != F3_OPIVV && inst[14:12] != F3_OPIVX) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal encodings still flow, but carry no operands.
    if (dec.illegal) begin
      dec.rs1    = '0;
      dec.rs2    = '0;
      dec.rd     = '0;
      dec.imm    = '0;
      dec.funct6 = '0;
      dec.vm     = 1'b0;
    end
  end

  // in_ready depends only on skid occupancy and reset, never on out_ready.
  assign in_ready = !s_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign transfer = m_valid && out_ready;

  // M/S occupancy and data: reset beats flush beats the handshakes; FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      // Data registers are deliberately left as they are.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      // in_ready is low, so only the S -> M move can happen here.
      if (transfer) begin
        m_data  <= s_data;
        s_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!m_valid || transfer) begin
        m_data  <= dec;
        m_valid <= 1'b1;
      end else begin
        s_data  <= dec;
        s_valid <= 1'b1;
      end
    end else if (transfer) begin
      m_valid <= 1'b0;
    end
  end

  assign out_valid   = m_valid;
  assign out_opt     = m_data.opt;
  assign out_funct3  = m_data.funct3;
  assign out_funct6  = m_data.funct6;
  assign out_rs1     = m_data.rs1;
  assign out_rs2     = m_data.rs2;
  assign out_rd      = m_data.rd;
  assign out_imm     = m_data.imm;
  assign out_vm      = m_data.vm;
  assign out_pc      = m_data.pc;
  assign out_illegal = m_data.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset values, the main instruction formats,
// back-pressure through the skid entry, illegal encodings, flush and reset
// while full. Inputs change just after the falling edge; outputs are sampled
// at the falling edge, away from the rising capture edge.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opt;
  logic [2:0]  out_funct3;
  logic [5:0]  out_funct6;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_vm;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  decode_stage #(
    .INST_WIDTH(32),
    .DATA_WIDTH(32),
    .PC_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opt    (out_opt),
    .out_funct3 (out_funct3),
    .out_funct6 (out_funct6),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .out_vm     (out_vm),
    .out_pc     (out_pc),
    .out_illegal(out_illegal)
  );

  // Clock and a hard time limit so the run always ends.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed no end of test, expected end before 100000");
    $fatal(1, "timeout");
  end

  // Advance to the next sampling point.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of a presented instruction.
  task automatic expect_out(input string tag, input logic [6:0] opt, input logic [2:0] f3,
                            input logic [5:0] f6, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] imm, input logic vm,
                            input logic [31:0] pc, input logic ill);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".opt"}, {25'b0, out_opt}, {25'b0, opt});
    chk({tag, ".funct3"}, {29'b0, out_funct3}, {29'b0, f3});
    chk({tag, ".funct6"}, {26'b0, out_funct6}, {26'b0, f6});
    chk({tag, ".rs1"}, {27'b0, out_rs1}, {27'b0, rs1});
    chk({tag, ".rs2"}, {27'b0, out_rs2}, {27'b0, rs2});
    chk({tag, ".rd"}, {27'b0, out_rd}, {27'b0, rd});
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".vm"}, {31'b0, out_vm}, {31'b0, vm});
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
  endtask

  // Reset-state image: not valid and every data output zero.
  task automatic expect_reset(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, ".opt"}, {25'b0, out_opt}, 32'd0);
    chk({tag, ".funct3"}, {29'b0, out_funct3}, 32'd0);
    chk({tag, ".funct6"}, {26'b0, out_funct6}, 32'd0);
    chk({tag, ".rs1"}, {27'b0, out_rs1}, 32'd0);
    chk({tag, ".rs2"}, {27'b0, out_rs2}, 32'd0);
    chk({tag, ".rd"}, {27'b0, out_rd}, 32'd0);
    chk({tag, ".imm"}, out_imm, 32'd0);
    chk({tag, ".vm"}, {31'b0, out_vm}, 32'd0);
    chk({tag, ".pc"}, out_pc, 32'd0);
    chk({tag, ".illegal"}, {31'b0, out_illegal}, 32'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  // addi x1,x0,n: used as easily told-apart payloads.
  function automatic logic [31:0] addi_n(input int n);
    return (32'(n) << 20) | 32'h0000_0093;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // ---- reset ----
    step(); step();
    expect_reset("rst");
    rst = 1'b0;
    step();
    chk("post_rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst.valid", {31'b0, out_valid}, 32'd0);

    // ---- addi x1,x2,-1 ----
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF10093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    expect_out("addi", 7'h13, 3'd0, 6'd0, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b0, 32'h100, 1'b0);
    step();
    chk("addi_drain.valid", {31'b0, out_valid}, 32'd0);

    // ---- four-instruction stream, out_ready = 1 ----
    drive(1'b1, 32'hFE208EE3, 32'h200);
    step();
    drive(1'b1, 32'h008000EF, 32'h204);
    expect_out("beq", 7'h63, 3'd0, 6'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 32'h200, 1'b0);
    step();
    drive(1'b1, 32'h123452B7, 32'h208);
    expect_out("jal", 7'h6F, 3'd0, 6'd0, 5'd0, 5'd0, 5'd1, 32'h8, 1'b0, 32'h204, 1'b0);
    step();
    drive(1'b1, 32'h022081D7, 32'h20C);
    expect_out("lui", 7'h37, 3'd5, 6'd0, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b0, 32'h208, 1'b0);
    step();
    // Extra formats keep streaming: vadd.vi v3,v2,-1; srai x1,x2,3; sub x3,x1,x2.
    drive(1'b1, 32'h022FB1D7, 32'h210);
    expect_out("vadd_vv", 7'h57, 3'd0, 6'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h20C, 1'b0);
    step();
    drive(1'b1, 32'h40315093, 32'h214);
    expect_out("vadd_vi", 7'h57, 3'd3, 6'd0, 5'd31, 5'd2, 5'd3, 32'hFFFFFFFF, 1'b1, 32'h210, 1'b0);
    step();
    drive(1'b1, 32'h402081B3, 32'h218);
    expect_out("srai", 7'h13, 3'd5, 6'h10, 5'd2, 5'd0, 5'd1, 32'h403, 1'b0, 32'h214, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    expect_out("sub", 7'h33, 3'd0, 6'h10, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h218, 1'b0);
    step();
    chk("stream_drain.valid", {31'b0, out_valid}, 32'd0);

    // ---- back-pressure: A,B,C,D with out_ready low for 3 cycles ----
    out_ready = 1'b0;
    drive(1'b1, addi_n(1), 32'hA00);
    step();
    chk("bp_a_in.in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, addi_n(2), 32'hB00);
    step();
    chk("bp_hold1.in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_hold1.pc", out_pc, 32'hA00);
    drive(1'b1, addi_n(3), 32'hC00);
    step();
    chk("bp_hold2.in_ready", {31'b0, in_ready}, 32'd0);
    expect_out("bp_hold2", 7'h13, 3'd0, 6'd0, 5'd0, 5'd0, 5'd1, 32'd1, 1'b0, 32'hA00, 1'b0);
    out_ready = 1'b1;
    step();
    chk("bp_b.in_ready", {31'b0, in_ready}, 32'd1);
    expect_out("bp_b", 7'h13, 3'd0, 6'd0, 5'd0, 5'd0, 5'd1, 32'd2, 1'b0, 32'hB00, 1'b0);
    step();
    drive(1'b1, addi_n(4), 32'hD00);
    expect_out("bp_c", 7'h13, 3'd0, 6'd0, 5'd0, 5'd0, 5'd1, 32'd3, 1'b0, 32'hC00, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    expect_out("bp_d", 7'h13, 3'd0, 6'd0, 5'd0, 5'd0, 5'd1, 32'd4, 1'b0, 32'hD00, 1'b0);
    step();
    chk("bp_drain.valid", {31'b0, out_valid}, 32'd0);

    // ---- illegal encodings ----
    drive(1'b1, 32'h0000000B, 32'h300);
    step();
    drive(1'b1, 32'h02209157, 32'h304);
    expect_out("ill_custom0", 7'h0B, 3'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h300, 1'b1);
    step();
    drive(1'b1, 32'h00000000, 32'h308);
    expect_out("ill_opv_f3", 7'h57, 3'd1, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h304, 1'b1);
    step();
    // jalr x1,x2,4 with funct3 = 001.
    drive(1'b1, 32'h004110E7, 32'h30C);
    expect_out("ill_zero", 7'h00, 3'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h308, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    expect_out("ill_jalr", 7'h67, 3'd1, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h30C, 1'b1);
    step();

    // ---- flush with M and S full, concurrent fetch offer ----
    out_ready = 1'b0;
    drive(1'b1, addi_n(5), 32'h400);
    step();
    drive(1'b1, addi_n(6), 32'h404);
    step();
    chk("fl_full.in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, addi_n(7), 32'h408);
    step();
    flush = 1'b0;
    chk("fl_full.valid", {31'b0, out_valid}, 32'd0);
    chk("fl_full.in_ready_after", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(1'b1, addi_n(8), 32'h40C);
    step();
    drive(1'b0, 32'h0, 32'h0);
    expect_out("fl_first", 7'h13, 3'd0, 6'd0, 5'd0, 5'd0, 5'd1, 32'd8, 1'b0, 32'h40C, 1'b0);
    step();
    chk("fl_drain.valid", {31'b0, out_valid}, 32'd0);

    // ---- flush drops an accept that would otherwise land in S ----
    out_ready = 1'b0;
    drive(1'b1, addi_n(9), 32'h500);
    step();
    flush = 1'b1;
    drive(1'b1, addi_n(10), 32'h504);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_drop.valid", {31'b0, out_valid}, 32'd0);
    chk("fl_drop.in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_drop_later.valid", {31'b0, out_valid}, 32'd0);

    // ---- reset (with flush) while M and S are full ----
    out_ready = 1'b0;
    drive(1'b1, addi_n(11), 32'h600);
    step();
    drive(1'b1, addi_n(12), 32'h604);
    step();
    chk("rst_full.in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    expect_reset("rst_full");
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rst_after.valid", {31'b0, out_valid}, 32'd0);
    chk("rst_after.in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("rst_after2.valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
